loopback_err_checker: RTL

Checks a 10GbE loopback path by comparing every word returned on the receive side against the word previously sent on the transmit side. It counts mismatches in a saturating 32-bit error counter. It sits directly upstream of the `lb_err_cnt` software register: `err_cnt` drives that register's `user_data_in`, and both run on `user_clk`. It also exports a compared-word count and sticky overflow/underflow flags for neighbouring status registers.

---
 rtl/loopback_err_checker_if.sv | 12 +
 rtl/loopback_err_checker.sv | 93 +++++++++
 2 files changed

// File: rtl/loopback_err_checker_if.sv
// Transmit/receive word streams of the loopback path under test.
interface loopback_err_checker_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;

    modport master (output tx_data, output tx_valid, output rx_data, output rx_valid);
    modport slave  (input  tx_data, input  tx_valid, input  rx_data, input  rx_valid);
endinterface

// File: rtl/loopback_err_checker.sv
// Loopback error checker: buffers transmitted words in a FIFO and compares
// each returned word against the oldest buffered one. Mismatches and
// empty-FIFO returns are counted one cycle after the compare is sampled.
module loopback_err_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_AW    = 4
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    loopback_err_checker_if.slave  lb,
    input  logic                   cnt_clr,
    output logic [31:0]            err_cnt,
    output logic [31:0]            word_cnt,
    output logic                   ovf,
    output logic                   unf,
    output logic [FIFO_AW:0]       fifo_level
);
    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head;
    logic                  err_evt_q, err_evt_d, word_evt_q, word_evt_d;
    logic [31:0]           err_cnt_q, err_cnt_d, word_cnt_q, word_cnt_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);
    assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    // Pointer, compare-event and status next state. Empty is judged on the
    // registered level, so a same-cycle push never feeds a pop.
    always_comb begin
        pop        = lb.rx_valid && !empty;
        push       = lb.tx_valid && (!full || pop);
        wr_ptr_d   = wr_ptr_q + (push ? 1'b1 : 1'b0);
        rd_ptr_d   = rd_ptr_q + (pop  ? 1'b1 : 1'b0);
        err_evt_d  = lb.rx_valid && (empty || (head != lb.rx_data));
        word_evt_d = lb.rx_valid;
        ovf_d      = cnt_clr ? 1'b0 : (ovf_q | (lb.tx_valid && full && !pop));
        unf_d      = cnt_clr ? 1'b0 : (unf_q | (lb.rx_valid && empty));
    end

    // Saturating counters; a clear on the same edge discards the pending event.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        if (cnt_clr) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            if (err_evt_q  && (err_cnt_q  != '1)) err_cnt_d  = err_cnt_q  + 32'd1;
            if (word_evt_q && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 32'd1;
        end
    end

    // Expected-word storage; contents need no reset since pointers gate reads.
    always_ff @(posedge user_clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= lb.tx_data;
    end

    // State registers; reset also drops any compare result still in flight.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_evt_q  <= 1'b0;
            word_evt_q <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_evt_q  <= err_evt_d;
            word_evt_q <= word_evt_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign err_cnt    = err_cnt_q;
    assign word_cnt   = word_cnt_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign fifo_level = level;
endmodule
